// File: rtl/ekf_pkg.sv
// Shared constants for the EKF-SLAM stage sequencer: stage codes, fixed-point
// operand layout, default stage work windows and the sequencer state type.
package ekf_pkg;

  localparam logic [2:0] STAGE_IDLE  = 3'b000;
  localparam logic [2:0] STAGE_PRD   = 3'b001;
  localparam logic [2:0] STAGE_NEW   = 3'b010;
  localparam logic [2:0] STAGE_UPD   = 3'b011;
  localparam logic [2:0] STAGE_ASSOC = 3'b100;

  localparam int DATA_INT_BIT = 12;
  localparam int DATA_DEC_BIT = 19;

  localparam int PRD_WORK_DFLT   = 600;
  localparam int NEW_WORK_DFLT   = 500;
  localparam int UPD_WORK_DFLT   = 500;
  localparam int ASSOC_WORK_DFLT = 400;

  // Wide enough for any work window a host would reasonably configure.
  localparam int CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ekf_slam_stage_timer.sv
// Loadable down-counter for the stage work window; done is high while the
// count sits at 1, i.e. on the last busy cycle.
module stage_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/ekf_slam_top.sv
// EKF-SLAM stage sequencer: accepts host stage commands, latches operands,
// times each stage's work window and counts initialized landmarks.
// Define STAGE_ASSOC_EN to make the association stage (code 100) legal.
module ekf_slam_top
  import ekf_pkg::*;
#(
  parameter int RSA_DW     = 1 + DATA_INT_BIT + DATA_DEC_BIT,
  parameter int ROW_LEN    = 10,
  parameter int PRD_WORK   = PRD_WORK_DFLT,
  parameter int NEW_WORK   = NEW_WORK_DFLT,
  parameter int UPD_WORK   = UPD_WORK_DFLT,
  parameter int ASSOC_WORK = ASSOC_WORK_DFLT
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic [2:0]               stage_val,
  input  logic signed [RSA_DW-1:0] vlr,
  input  logic signed [RSA_DW-1:0] alpha,
  input  logic signed [RSA_DW-1:0] rk,
  input  logic signed [RSA_DW-1:0] phi,
  output logic                     stage_rdy,
  output logic [2:0]               stage_cur,
  output logic [ROW_LEN-1:0]       landmark_num
);

  seq_state_t              state, state_nxt;
  logic                    cmd_legal;
  logic                    accept;
  logic                    timer_done;
  logic                    stage_end;
  logic [CNT_W-1:0]        work_sel;
  logic signed [RSA_DW-1:0] vlr_q, alpha_q, rk_q, phi_q;
  logic                    operand_unused;

  // Decode the command and pick its work window; UPD/ASSOC with no landmarks
  // have nothing to process, so they collapse to a single cycle.
  always_comb begin
    cmd_legal = 1'b0;
    work_sel  = '0;
    case (stage_val)
      STAGE_PRD: begin
        cmd_legal = 1'b1;
        work_sel  = CNT_W'(PRD_WORK);
      end
      STAGE_NEW: begin
        cmd_legal = 1'b1;
        work_sel  = CNT_W'(NEW_WORK);
      end
      STAGE_UPD: begin
        cmd_legal = 1'b1;
        work_sel  = (landmark_num == '0) ? CNT_W'(1) : CNT_W'(UPD_WORK);
      end
`ifdef STAGE_ASSOC_EN
      STAGE_ASSOC: begin
        cmd_legal = 1'b1;
        work_sel  = (landmark_num == '0) ? CNT_W'(1) : CNT_W'(ASSOC_WORK);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_legal) begin
          accept    = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (timer_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  assign stage_end = (state == ST_BUSY) && timer_done;
  assign stage_rdy = (state == ST_IDLE);

  stage_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (sys_rst),
    .load     (accept),
    .load_val (work_sel),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      stage_cur    <= STAGE_IDLE;
      landmark_num <= '0;
    end else if (accept) begin
      stage_cur <= stage_val;
    end else if (stage_end) begin
      stage_cur <= STAGE_IDLE;
      if (stage_cur == STAGE_NEW && landmark_num != {ROW_LEN{1'b1}})
        landmark_num <= landmark_num + 1'b1;
    end
  end

  // Operands stay frozen for the whole stage for the datapath fed from here.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      vlr_q   <= '0;
      alpha_q <= '0;
      rk_q    <= '0;
      phi_q   <= '0;
    end else if (accept) begin
      vlr_q   <= vlr;
      alpha_q <= alpha;
      rk_q    <= rk;
      phi_q   <= phi;
    end
  end

  // The operand consumers live outside this slice of the accelerator.
  assign operand_unused = ^{vlr_q, alpha_q, rk_q, phi_q};

endmodule

// File: tb/tb_ekf_slam_top.sv
// Bench for ekf_slam_top: directed vector table, randomized commands against a
// stage-level model, and reset / saturation corner sequences.
module tb_ekf_slam_top;

  logic               clk = 1'b0;
  logic               sys_rst;
  logic [2:0]         stage_val, stage_val_s;
  logic signed [31:0] vlr, alpha, rk, phi;
  logic               stage_rdy, stage_rdy_s;
  logic [2:0]         stage_cur, stage_cur_s;
  logic [9:0]         landmark_num;
  logic [1:0]         landmark_num_s;

  int n_pass  = 0;
  int n_total = 0;
  int lm_model;

`ifdef STAGE_ASSOC_EN
  localparam int ASSOC_EXP = 400;
`else
  localparam int ASSOC_EXP = 0;
`endif

  always #5 clk = ~clk;

  ekf_slam_top dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .stage_val    (stage_val),
    .vlr          (vlr),
    .alpha        (alpha),
    .rk           (rk),
    .phi          (phi),
    .stage_rdy    (stage_rdy),
    .stage_cur    (stage_cur),
    .landmark_num (landmark_num)
  );

  // Tiny instance so landmark saturation is reachable in a few cycles.
  ekf_slam_top #(
    .ROW_LEN    (2),
    .PRD_WORK   (3),
    .NEW_WORK   (2),
    .UPD_WORK   (2),
    .ASSOC_WORK (2)
  ) dut_sat (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .stage_val    (stage_val_s),
    .vlr          (32'sd0),
    .alpha        (32'sd0),
    .rk           (32'sd0),
    .phi          (32'sd0),
    .stage_rdy    (stage_rdy_s),
    .stage_cur    (stage_cur_s),
    .landmark_num (landmark_num_s)
  );

  typedef struct {
    string              name;
    logic [2:0]         code;
    int                 hold;
    logic signed [31:0] v, a, r, p;
    int                 exp_len;
    int                 exp_lm;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Stage-level model: busy length of a command given the current landmark count.
  function automatic int model_len(input logic [2:0] code, input int lm);
    case (code)
      3'b001:  return 600;
      3'b010:  return 500;
      3'b011:  return (lm == 0) ? 1 : 500;
      3'b100:  return (ASSOC_EXP == 0) ? 0 : ((lm == 0) ? 1 : ASSOC_EXP);
      default: return 0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where stage_rdy is seen high again.
  task automatic run_cmd(input string name, input logic [2:0] code, input int hold,
                         input logic signed [31:0] v, input logic signed [31:0] a,
                         input logic signed [31:0] r, input logic signed [31:0] p,
                         input int exp_len, input int exp_lm);
    int         cnt;
    bit         cur_bad, lm_bad, timed_out;
    logic [9:0] lm0;
    cnt = 0; cur_bad = 0; lm_bad = 0; timed_out = 1;
    lm0 = landmark_num;
    stage_val = code; vlr = v; alpha = a; rk = r; phi = p;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c + 1 >= hold) stage_val = 3'b000;
      if (stage_rdy) begin
        timed_out = 0;
        break;
      end
      cnt++;
      if (stage_cur !== code) cur_bad = 1;
      if (landmark_num !== lm0) lm_bad = 1;
    end
    stage_val = 3'b000;
    check({name, " timeout"}, timed_out, 0);
    check({name, " busy_len"}, cnt, exp_len);
    check({name, " cur_in_window"}, cur_bad, 0);
    check({name, " lm_in_window"}, lm_bad, 0);
    check({name, " cur_after"}, stage_cur, 0);
    check({name, " lm_after"}, landmark_num, exp_lm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"prd_hold2",   3'b001, 2, 32'sd0, -32'sd2221, 32'sd0, 32'sd0, 600, 0};
    vecs[1] = '{"upd_lm0",     3'b011, 2, 32'sd5, 32'sd6, 32'sd7, 32'sd8, 1, 0};
    vecs[2] = '{"new_a",       3'b010, 1, 32'sd1, -32'sd1, 32'sd100, -32'sd100, 500, 1};
    vecs[3] = '{"new_b",       3'b010, 1, -32'sd7, 32'sd9, 32'sd200, 32'sd300, 500, 2};
    vecs[4] = '{"upd_lm2",     3'b011, 1, 32'sd0, 32'sd0, 32'sd11, 32'sd12, 500, 2};
    vecs[5] = '{"assoc",       3'b100, 1, 32'sd0, 32'sd0, 32'sd10730636, -32'sd359159, ASSOC_EXP, 2};
    vecs[6] = '{"illegal_111", 3'b111, 3, 32'sd3, 32'sd3, 32'sd3, 32'sd3, 0, 2};
    vecs[7] = '{"idle_000",    3'b000, 2, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 0, 2};

    sys_rst = 1'b1; stage_val = 3'b000; stage_val_s = 3'b000;
    vlr = '0; alpha = '0; rk = '0; phi = '0;
    repeat (2) @(negedge clk);
    check("reset rdy", stage_rdy, 1);
    check("reset cur", stage_cur, 0);
    check("reset lm", landmark_num, 0);
    check("reset sat rdy", stage_rdy_s, 1);
    sys_rst = 1'b0;
    @(negedge clk);

    // Landmark counter saturates at 2^ROW_LEN-1 on the small instance.
    for (int i = 0; i < 5; i++) begin
      bit to;
      to = 1;
      stage_val_s = 3'b010;
      @(negedge clk);
      stage_val_s = 3'b000;
      for (int c = 0; c < 20; c++) begin
        if (stage_rdy_s) begin
          to = 0;
          break;
        end
        @(negedge clk);
      end
      check("sat timeout", to, 0);
      check("sat lm", landmark_num_s, (i + 1 > 3) ? 3 : i + 1);
    end

    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].name, vecs[i].code, vecs[i].hold, vecs[i].v, vecs[i].a,
              vecs[i].r, vecs[i].p, vecs[i].exp_len, vecs[i].exp_lm);

    lm_model = 2;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] code;
      int         hold, exp_len;
      code    = 3'($urandom_range(0, 7));
      hold    = $urandom_range(1, 3);
      exp_len = model_len(code, lm_model);
      if (code == 3'b010 && exp_len != 0 && lm_model < 1023) lm_model++;
      run_cmd("rand", code, hold, $signed($urandom), $signed($urandom),
              $signed($urandom), $signed($urandom), exp_len, lm_model);
    end

    // Reset wins over a command presented on the same edge.
    stage_val = 3'b001;
    sys_rst   = 1'b1;
    @(negedge clk);
    check("rst_prio rdy", stage_rdy, 1);
    check("rst_prio cur", stage_cur, 0);
    check("rst_prio lm", landmark_num, 0);
    sys_rst   = 1'b0;
    stage_val = 3'b000;
    @(negedge clk);
    check("rst_prio stays idle", stage_rdy, 1);

    run_cmd("new_after_rst", 3'b010, 1, 32'sd0, 32'sd0, 32'sd1, 32'sd1, 500, 1);

    // Reset 100 cycles into a predict stage aborts it and clears the landmark count.
    stage_val = 3'b001;
    @(negedge clk);
    stage_val = 3'b000;
    repeat (99) @(negedge clk);
    check("mid_prd busy", stage_rdy, 0);
    check("mid_prd cur", stage_cur, 1);
    sys_rst = 1'b1;
    @(negedge clk);
    check("mid_rst rdy", stage_rdy, 1);
    check("mid_rst cur", stage_cur, 0);
    check("mid_rst lm", landmark_num, 0);
    sys_rst = 1'b0;
    @(negedge clk);

    run_cmd("upd_after_abort", 3'b011, 1, 32'sd0, 32'sd0, 32'sd2, 32'sd2, 1, 0);
    run_cmd("prd_after_abort", 3'b001, 1, -32'sd1, -32'sd1, 32'sd0, 32'sd0, 600, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
